// File: rtl/conv_pkg.sv
// Shared types and elaboration-time helpers for the sequential convolution engine.
package conv_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StMac,
    StEmit,
    StDone
  } state_e;

  localparam logic CONV = 1'b0;
  localparam logic CORR = 1'b1;

  function automatic int unsigned clog2(input int unsigned v);
    for (int unsigned i = 0; i < 31; i++) begin
      if ((32'd1 << i) >= v) return i;
    end
    return 31;
  endfunction

  function automatic int unsigned min(input int unsigned a, input int unsigned b);
    return (a < b) ? a : b;
  endfunction

  function automatic int unsigned max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned idx_w(input int unsigned n);
    return (clog2(n) == 0) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/conv_mac.sv
// Registered multiply-accumulate with synchronous clear and enable.
// CONV_SIGNED_EN selects two's-complement operands; otherwise everything is unsigned.
module conv_mac #(
  parameter int unsigned DW    = 8,
  parameter int unsigned OUT_W = 2 * DW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DW-1:0]    a_i,
  input  logic [DW-1:0]    b_i,
  output logic [OUT_W-1:0] acc_o
);

  logic [2*DW-1:0]  prod;
  logic [OUT_W-1:0] prod_ext;
  logic [OUT_W-1:0] acc_d, acc_q;

  always_comb begin
`ifdef CONV_SIGNED_EN
    prod     = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
    prod_ext = {{(OUT_W - 2 * DW){prod[2*DW-1]}}, prod};
`else
    prod     = {{DW{1'b0}}, a_i} * {{DW{1'b0}}, b_i};
    prod_ext = {{(OUT_W - 2 * DW){1'b0}}, prod};
`endif
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + prod_ext;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/seq_conv_engine.sv
// Sequential 1-D convolution/correlation: serial load of A then B, one MAC per cycle,
// one full-precision output per valid/ready handshake.
module seq_conv_engine
  import conv_pkg::*;
#(
  parameter int unsigned N_A   = 16,
  parameter int unsigned N_B   = 16,
  parameter int unsigned DW    = 8,
  parameter int unsigned OUT_W = 2 * DW + clog2(min(N_A, N_B)) + 1,
  parameter int unsigned IDX_W = idx_w(N_A + N_B - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             corr_mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             invalid_input
);

  localparam int unsigned AW    = idx_w(N_A);
  localparam int unsigned BW    = idx_w(N_B);
  localparam int unsigned CW    = max(AW, BW);
  localparam int unsigned KLast = N_A + N_B - 2;

  state_e           state_q, state_d;
  logic [DW-1:0]    a_q [N_A];
  logic [DW-1:0]    a_d [N_A];
  logic [DW-1:0]    b_q [N_B];
  logic [DW-1:0]    b_d [N_B];
  logic [CW-1:0]    ld_cnt_q, ld_cnt_d;
  logic [IDX_W-1:0] k_q, k_d;
  logic [AW-1:0]    j_q, j_d;
  logic             nz_a_q, nz_a_d;
  logic             nz_b_q, nz_b_d;
  logic             mode_q, mode_d;
  logic             invalid_q, invalid_d;

  logic             mac_clr, mac_en;
  logic [BW-1:0]    b_idx;
  logic [DW-1:0]    a_sel, b_sel;
  logic [OUT_W-1:0] acc;

  // First and last contributing A index for output k.
  function automatic int jmin_f(input int k);
    return (k >= int'(N_B) - 1) ? k - (int'(N_B) - 1) : 0;
  endfunction

  function automatic int jmax_f(input int k);
    return (k < int'(N_A) - 1) ? k : int'(N_A) - 1;
  endfunction

  // B tap for the current (k, j); correlation walks B from the far end.
  always_comb begin
    int kj;
    kj = int'(k_q) - int'(j_q);
    if (kj < 0 || kj >= int'(N_B)) kj = 0;
    if (mode_q == CORR) kj = int'(N_B) - 1 - kj;
    b_idx = BW'(kj);
  end

  assign a_sel = a_q[j_q];
  assign b_sel = b_q[b_idx];

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    ld_cnt_d  = ld_cnt_q;
    k_d       = k_q;
    j_d       = j_q;
    nz_a_d    = nz_a_q;
    nz_b_d    = nz_b_q;
    mode_d    = mode_q;
    invalid_d = invalid_q;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mode_d    = corr_mode;
          invalid_d = 1'b0;
          ld_cnt_d  = '0;
          k_d       = '0;
          j_d       = '0;
          nz_a_d    = 1'b0;
          nz_b_d    = 1'b0;
          state_d   = StLoadA;
        end
      end
      StLoadA: begin
        if (in_valid) begin
          a_d[AW'(ld_cnt_q)] = in_data;
          nz_a_d = nz_a_q | (in_data != '0);
          if (ld_cnt_q == CW'(N_A - 1)) begin
            ld_cnt_d = '0;
            state_d  = StLoadB;
          end else begin
            ld_cnt_d = ld_cnt_q + CW'(1);
          end
        end
      end
      StLoadB: begin
        if (in_valid) begin
          b_d[BW'(ld_cnt_q)] = in_data;
          nz_b_d = nz_b_q | (in_data != '0);
          if (ld_cnt_q == CW'(N_B - 1)) begin
            ld_cnt_d = '0;
            if (nz_a_q && nz_b_d) begin
              k_d     = '0;
              j_d     = '0;
              mac_clr = 1'b1;
              state_d = StMac;
            end else begin
              invalid_d = 1'b1;
              state_d   = StDone;
            end
          end else begin
            ld_cnt_d = ld_cnt_q + CW'(1);
          end
        end
      end
      StMac: begin
        mac_en = 1'b1;
        if (j_q == AW'(jmax_f(int'(k_q)))) begin
          state_d = StEmit;
        end else begin
          j_d = j_q + AW'(1);
        end
      end
      StEmit: begin
        if (out_ready) begin
          if (k_q == IDX_W'(KLast)) begin
            state_d = StDone;
          end else begin
            k_d     = k_q + IDX_W'(1);
            j_d     = AW'(jmin_f(int'(k_q) + 1));
            mac_clr = 1'b1;
            state_d = StMac;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      a_q       <= '{default: '0};
      b_q       <= '{default: '0};
      ld_cnt_q  <= '0;
      k_q       <= '0;
      j_q       <= '0;
      nz_a_q    <= 1'b0;
      nz_b_q    <= 1'b0;
      mode_q    <= CONV;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      ld_cnt_q  <= ld_cnt_d;
      k_q       <= k_d;
      j_q       <= j_d;
      nz_a_q    <= nz_a_d;
      nz_b_q    <= nz_b_d;
      mode_q    <= mode_d;
      invalid_q <= invalid_d;
    end
  end

  conv_mac #(
    .DW    (DW),
    .OUT_W (OUT_W)
  ) u_mac (
    .clk   (clk),
    .rst   (rst),
    .clr_i (mac_clr),
    .en_i  (mac_en),
    .a_i   (a_sel),
    .b_i   (b_sel),
    .acc_o (acc)
  );

  // The accumulator is frozen outside MAC, so it doubles as the held output register.
  assign in_ready      = (state_q == StLoadA) || (state_q == StLoadB);
  assign out_valid     = (state_q == StEmit);
  assign out_data      = acc;
  assign out_idx       = k_q;
  assign out_last      = (state_q == StEmit) && (k_q == IDX_W'(KLast));
  assign busy          = (state_q != StIdle);
  assign done          = (state_q == StDone);
  assign invalid_input = invalid_q;

endmodule

// File: tb/tb_seq_conv_engine.sv
// Directed self-checking bench for seq_conv_engine with N_A=N_B=4; expected outputs are
// hand-computed. Signed expectations apply when CONV_SIGNED_EN is defined.
module tb_seq_conv_engine;
  import conv_pkg::*;

  localparam int unsigned NA   = 4;
  localparam int unsigned NB   = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned OW   = 2 * DW + clog2(min(NA, NB)) + 1;
  localparam int unsigned KW   = idx_w(NA + NB - 1);
  localparam int          NOut = NA + NB - 1;

  typedef logic [DW-1:0] samp_t [NA];
  typedef logic [OW-1:0] res_t  [NOut];

  logic          clk, rst, start, corr_mode, in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready, out_last, busy, done, invalid_input;
  logic [OW-1:0] out_data;
  logic [KW-1:0] out_idx;

  int n_vec = 0;
  int n_err = 0;
  int done_cnt = 0;
  int n_out;
  logic [OW-1:0] got_data [NOut];
  logic [KW-1:0] got_idx  [NOut];
  logic          got_last [NOut];
  samp_t sa, sb;
  res_t  ex;

  seq_conv_engine #(
    .N_A (NA),
    .N_B (NB),
    .DW  (DW)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .corr_mode     (corr_mode),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_idx       (out_idx),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .invalid_input (invalid_input)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_and_load(input logic mode, input samp_t a, input samp_t b,
                                input bit rnd);
    int   idx = 0;
    int   cyc = 0;
    logic v, accept;
    @(negedge clk);
    start = 1'b1;
    corr_mode = mode;
    @(negedge clk);
    start = 1'b0;
    corr_mode = 1'b0;
    check_eq("inv_clr_on_start", invalid_input, 0);
    check_eq("busy_after_start", busy, 1);
    while (idx < 2 * NA && cyc < 200) begin
      v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      if (v) in_data = (idx < NA) ? a[idx] : b[idx-NA];
      else   in_data = 8'($urandom);
      accept = v && in_ready;
      @(negedge clk);
      cyc++;
      if (accept) idx++;
    end
    in_valid = 1'b0;
    in_data  = '0;
    if (idx < 2 * NA) check_eq("load_timeout", idx, 2 * NA);
  endtask

  task automatic drain(input res_t exp, input int stall_k);
    int cyc = 0;
    int d0 = done_cnt;
    int stall_left = 5;
    n_out = 0;
    out_ready = 1'b1;
    while (done_cnt == d0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (int'(out_idx) == stall_k && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
          check_eq("stall_data", out_data, exp[stall_k]);
        end else begin
          out_ready = 1'b1;
          if (n_out < NOut) begin
            got_data[n_out] = out_data;
            got_idx[n_out]  = out_idx;
            got_last[n_out] = out_last;
          end
          n_out++;
        end
      end
    end
    out_ready = 1'b1;
    if (cyc >= 1000) check_eq("done_timeout", done_cnt - d0, 1);
    if (stall_k >= 0) check_eq("stall_cycles", stall_left, 0);
    repeat (3) @(negedge clk);
    check_eq("done_pulses", done_cnt - d0, 1);
    check_eq("busy_idle", busy, 0);
  endtask

  task automatic check_results(input string tag, input res_t exp);
    check_eq($sformatf("%s_count", tag), n_out, NOut);
    for (int i = 0; i < NOut; i++) begin
      check_eq($sformatf("%s_y%0d", tag, i), got_data[i], exp[i]);
      check_eq($sformatf("%s_idx%0d", tag, i), got_idx[i], i);
      check_eq($sformatf("%s_last%0d", tag, i), got_last[i], (i == NOut - 1));
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; corr_mode = 1'b0; in_valid = 1'b0; in_data = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_idx", out_idx, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_invalid", invalid_input, 0);
    rst = 1'b0;

    // Convolution with a box filter.
    sa = '{8'd1, 8'd2, 8'd3, 8'd4};
    sb = '{8'd1, 8'd1, 8'd1, 8'd1};
    ex = '{19'd1, 19'd3, 19'd6, 19'd10, 19'd9, 19'd7, 19'd4};
    start_and_load(CONV, sa, sb, 1'b0);
    drain(ex, -1);
    check_results("conv", ex);
    check_eq("conv_invalid", invalid_input, 0);

    // Same job with back-pressure on y[2] and a gappy input stream.
    start_and_load(CONV, sa, sb, 1'b1);
    drain(ex, 2);
    check_results("stall", ex);

    // Correlation: B is applied time-reversed (1,2,0,1).
    sb = '{8'd1, 8'd0, 8'd2, 8'd1};
    ex = '{19'd1, 19'd4, 19'd7, 19'd11, 19'd10, 19'd3, 19'd4};
    start_and_load(CORR, sa, sb, 1'b0);
    drain(ex, -1);
    check_results("corr", ex);

    // All-zero A: no outputs, invalid flagged and held.
    sa = '{8'd0, 8'd0, 8'd0, 8'd0};
    sb = '{8'd5, 8'd1, 8'd2, 8'd3};
    start_and_load(CONV, sa, sb, 1'b0);
    drain(ex, -1);
    check_eq("zero_a_outputs", n_out, 0);
    check_eq("zero_a_invalid", invalid_input, 1);
    repeat (4) @(negedge clk);
    check_eq("zero_a_inv_held", invalid_input, 1);

    // All-zero B.
    sa = '{8'd1, 8'd0, 8'd0, 8'd0};
    sb = '{8'd0, 8'd0, 8'd0, 8'd0};
    start_and_load(CONV, sa, sb, 1'b0);
    drain(ex, -1);
    check_eq("zero_b_outputs", n_out, 0);
    check_eq("zero_b_invalid", invalid_input, 1);

    // Full-scale samples: peak of NA products without overflow.
    sa = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
    sb = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
`ifdef CONV_SIGNED_EN
    ex = '{19'd1, 19'd2, 19'd3, 19'd4, 19'd3, 19'd2, 19'd1};
`else
    ex = '{19'd65025, 19'd130050, 19'd195075, 19'd260100, 19'd195075, 19'd130050, 19'd65025};
`endif
    start_and_load(CONV, sa, sb, 1'b0);
    drain(ex, -1);
    check_results("full", ex);

    // Reset in the middle of the 4-cycle MAC for y[3].
    sa = '{8'd1, 8'd2, 8'd3, 8'd4};
    sb = '{8'd1, 8'd1, 8'd1, 8'd1};
    start_and_load(CONV, sa, sb, 1'b0);
    out_ready = 1'b1;
    cyc = 0;
    while (!(out_valid && int'(out_idx) == 2) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check_eq("mid_busy", busy, 1);
    check_eq("mid_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("arst_busy", busy, 0);
    check_eq("arst_out_data", out_data, 0);
    check_eq("arst_out_idx", out_idx, 0);
    check_eq("arst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    sb = '{8'd1, 8'd0, 8'd2, 8'd1};
    ex = '{19'd1, 19'd4, 19'd7, 19'd11, 19'd10, 19'd3, 19'd4};
    start_and_load(CORR, sa, sb, 1'b0);
    drain(ex, -1);
    check_results("post_rst", ex);

`ifdef CONV_SIGNED_EN
    // -1 * 2 must come out as -2 in OW-bit two's complement.
    sa = '{8'hFF, 8'd0, 8'd0, 8'd0};
    sb = '{8'd2, 8'd0, 8'd0, 8'd0};
    ex = '{default: '0};
    ex[0] = ~OW'(1);
    start_and_load(CONV, sa, sb, 1'b0);
    drain(ex, -1);
    check_results("signed", ex);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
